// File: rtl/nf10_upb_axis_upsizer.sv
// nf10_upb_axis_upsizer: packs narrow MAC-side AXI-Stream beats into wide beats,
// stamps packet metadata, truncates oversize frames and counts packets.
module nf10_upb_axis_upsizer #(
   parameter int C_S_DATA_WIDTH        = 64,
   parameter int C_AXIS_DATA_WIDTH     = 256,
   parameter int C_INPORT_WIDTH        = 3,
   parameter int C_OUTPORT_WIDTH       = 8,
   parameter int C_PACKET_LENGTH_WIDTH = 14,
   parameter int C_PORT_NUMBER         = 0,
   parameter int C_MAX_PACKET_LENGTH   = 10000
) (
   input  logic                               axi_aclk,
   input  logic                               axi_reset,
   input  logic [C_S_DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [C_S_DATA_WIDTH/8-1:0]        s_axis_tkeep,
   input  logic                               s_axis_tuser,
   input  logic                               s_axis_tvalid,
   input  logic                               s_axis_tlast,
   output logic                               s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [C_PACKET_LENGTH_WIDTH-1:0]   m_axis_tuser_packet_length,
   output logic [C_INPORT_WIDTH-1:0]          m_axis_tuser_in_port,
   output logic [C_INPORT_WIDTH-1:0]          m_axis_tuser_in_vport,
   output logic [C_OUTPORT_WIDTH-1:0]         m_axis_tuser_out_port,
   output logic [C_OUTPORT_WIDTH-1:0]         m_axis_tuser_out_vport,
   output logic                               m_axis_tuser_bad,
   output logic                               m_axis_tvalid,
   output logic                               m_axis_tlast,
   input  logic                               m_axis_tready,
   output logic [31:0]                        stat_pkt_count,
   output logic [31:0]                        stat_bad_count
);

   localparam int SW  = C_S_DATA_WIDTH;
   localparam int SK  = C_S_DATA_WIDTH / 8;
   localparam int MW  = C_AXIS_DATA_WIDTH;
   localparam int MK  = C_AXIS_DATA_WIDTH / 8;
   localparam int N   = MW / SW;
   localparam int LW  = $clog2(N);
   localparam int PLW = C_PACKET_LENGTH_WIDTH;

   localparam logic [PLW-1:0] MAX_LEN   = PLW'(C_MAX_PACKET_LENGTH);
   localparam logic [LW-1:0]  LAST_LANE = LW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DISCARD
   } state_t;

   state_t          state;
   logic [LW-1:0]   lane;
   logic [PLW-1:0]  byte_cnt;
   logic [MW-1:0]   acc_data;
   logic [MK-1:0]   acc_keep;

   logic [PLW-1:0]  beat_bytes;
   logic [PLW-1:0]  next_cnt;
   logic [SW-1:0]   lane_data;
   logic [MW-1:0]   wide_data;
   logic [MK-1:0]   wide_keep;
   logic            accept;
   logic            trunc;
   logic            pkt_end;
   logic            complete;

   assign m_axis_tuser_in_port   = C_INPORT_WIDTH'(C_PORT_NUMBER);
   assign m_axis_tuser_in_vport  = C_INPORT_WIDTH'(C_PORT_NUMBER);
   assign m_axis_tuser_out_port  = '0;
   assign m_axis_tuser_out_vport = '0;

   // Accept whenever the output register is free; drain freely while discarding.
   assign s_axis_tready = !axi_reset &&
                          ((state == DISCARD) || !m_axis_tvalid || m_axis_tready);

   assign accept   = s_axis_tvalid && s_axis_tready;
   assign next_cnt = byte_cnt + beat_bytes;
   assign trunc    = !s_axis_tlast && (next_cnt > MAX_LEN);
   assign pkt_end  = s_axis_tlast || trunc;
   assign complete = (lane == LAST_LANE) || pkt_end;

   // Byte count of the incoming beat (tkeep is contiguous, so popcount is exact).
   always_comb begin
      beat_bytes = '0;
      for (int b = 0; b < SK; b++)
         beat_bytes = beat_bytes + PLW'(s_axis_tkeep[b]);
   end

   // Merge the current narrow beat into its lane; unkept bytes read as zero.
   always_comb begin
      lane_data = '0;
      for (int b = 0; b < SK; b++)
         lane_data[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
      wide_data = acc_data;
      wide_keep = acc_keep;
      for (int k = 0; k < N; k++) begin
         if (lane == LW'(k)) begin
            wide_data[k*SW +: SW] = lane_data;
            wide_keep[k*SK +: SK] = s_axis_tkeep;
         end
      end
   end

   // Packing FSM, registered output beat and statistics.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state                      <= IDLE;
         lane                       <= '0;
         byte_cnt                   <= '0;
         acc_data                   <= '0;
         acc_keep                   <= '0;
         m_axis_tvalid              <= 1'b0;
         m_axis_tlast               <= 1'b0;
         m_axis_tuser_bad           <= 1'b0;
         m_axis_tdata               <= '0;
         m_axis_tkeep               <= '0;
         m_axis_tuser_packet_length <= '0;
         stat_pkt_count             <= '0;
         stat_bad_count             <= '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            if (m_axis_tlast) begin
               stat_pkt_count <= stat_pkt_count + 32'd1;
               if (m_axis_tuser_bad)
                  stat_bad_count <= stat_bad_count + 32'd1;
            end
         end
         if (accept) begin
            unique case (state)
               IDLE, ACCUM: begin
                  if (complete) begin
                     m_axis_tvalid              <= 1'b1;
                     m_axis_tdata               <= wide_data;
                     m_axis_tkeep               <= wide_keep;
                     m_axis_tuser_packet_length <= next_cnt;
                     m_axis_tlast               <= pkt_end;
                     m_axis_tuser_bad           <= (s_axis_tlast && s_axis_tuser) || trunc;
                     acc_data                   <= '0;
                     acc_keep                   <= '0;
                     lane                       <= '0;
                     byte_cnt                   <= pkt_end ? '0 : next_cnt;
                     if (trunc)
                        state <= DISCARD;
                     else if (s_axis_tlast)
                        state <= IDLE;
                     else
                        state <= ACCUM;
                  end else begin
                     acc_data <= wide_data;
                     acc_keep <= wide_keep;
                     lane     <= lane + LW'(1);
                     byte_cnt <= next_cnt;
                     state    <= ACCUM;
                  end
               end
               DISCARD: begin
                  if (s_axis_tlast)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nf10_upb_axis_upsizer.sv
// tb_nf10_upb_axis_upsizer: randomized self-checking bench with a packet-level
// reference model for the narrow-to-wide AXI-Stream upsizer.
module tb_nf10_upb_axis_upsizer;

   localparam int SW   = 64;
   localparam int MW   = 256;
   localparam int N    = MW / SW;
   localparam int SK   = SW / 8;
   localparam int MK   = MW / 8;
   localparam int PLW  = 14;
   localparam int MAXL = 10000;

   logic            aclk = 1'b0;
   logic            rst  = 1'b1;
   logic [SW-1:0]   s_axis_tdata = '0;
   logic [SK-1:0]   s_axis_tkeep = '0;
   logic            s_axis_tuser = 1'b0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tlast = 1'b0;
   logic            s_axis_tready;
   logic [MW-1:0]   m_axis_tdata;
   logic [MK-1:0]   m_axis_tkeep;
   logic [PLW-1:0]  m_len;
   logic [2:0]      m_in_port, m_in_vport;
   logic [7:0]      m_out_port, m_out_vport;
   logic            m_bad;
   logic            m_axis_tvalid;
   logic            m_axis_tlast;
   logic            m_axis_tready = 1'b1;
   logic [31:0]     stat_pkt_count, stat_bad_count;

   always #5 aclk = ~aclk;

   nf10_upb_axis_upsizer dut (
      .axi_aclk                   (aclk),
      .axi_reset                  (rst),
      .s_axis_tdata               (s_axis_tdata),
      .s_axis_tkeep               (s_axis_tkeep),
      .s_axis_tuser               (s_axis_tuser),
      .s_axis_tvalid              (s_axis_tvalid),
      .s_axis_tlast               (s_axis_tlast),
      .s_axis_tready              (s_axis_tready),
      .m_axis_tdata               (m_axis_tdata),
      .m_axis_tkeep               (m_axis_tkeep),
      .m_axis_tuser_packet_length (m_len),
      .m_axis_tuser_in_port       (m_in_port),
      .m_axis_tuser_in_vport      (m_in_vport),
      .m_axis_tuser_out_port      (m_out_port),
      .m_axis_tuser_out_vport     (m_out_vport),
      .m_axis_tuser_bad           (m_bad),
      .m_axis_tvalid              (m_axis_tvalid),
      .m_axis_tlast               (m_axis_tlast),
      .m_axis_tready              (m_axis_tready),
      .stat_pkt_count             (stat_pkt_count),
      .stat_bad_count             (stat_bad_count)
   );

   typedef struct packed {
      logic [MW-1:0]  d;
      logic [MK-1:0]  k;
      logic [PLW-1:0] len;
      logic           last;
      logic           bad;
   } wbeat_t;

   typedef struct packed {
      logic [SW-1:0] d;
      logic [SK-1:0] k;
      logic          last;
      logic          user;
   } nbeat_t;

   nbeat_t pkt[$];
   wbeat_t exp_q[$];
   wbeat_t obs_q[$];
   int     tests = 0;
   int     fails = 0;
   int     exp_pkts = 0;
   int     exp_bad = 0;
   bit     rand_rdy = 1'b0;
   bit     send_done;
   wbeat_t mon_w;

   // Capture every output handshake.
   always @(negedge aclk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         mon_w.d    = m_axis_tdata;
         mon_w.k    = m_axis_tkeep;
         mon_w.len  = m_len;
         mon_w.last = m_axis_tlast;
         mon_w.bad  = m_bad;
         obs_q.push_back(mon_w);
      end
   end

   // Random downstream backpressure when enabled.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (rand_rdy)
            m_axis_tready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic build_pkt(input int nbytes, input bit user, input bit zeros);
      int full, rem, nb;
      nbeat_t b;
      pkt.delete();
      full = nbytes / SK;
      rem  = nbytes % SK;
      nb   = full + int'(rem != 0);
      for (int i = 0; i < nb; i++) begin
         if (zeros && i > 0 && $urandom_range(0, 7) == 0) begin
            b.d    = {$urandom, $urandom};
            b.k    = '0;
            b.last = 1'b0;
            b.user = 1'($urandom);
            pkt.push_back(b);
         end
         b.d = {$urandom, $urandom};
         b.k = '1;
         if (i == nb - 1 && rem != 0)
            b.k = SK'((1 << rem) - 1);
         b.last = (i == nb - 1);
         b.user = b.last ? user : 1'($urandom);
         pkt.push_back(b);
      end
   endtask

   // Reference: group narrow beats N at a time, cut at last or at the first
   // non-last beat whose running byte total exceeds the maximum.
   task automatic model_pkt();
      wbeat_t cur;
      int     cum, lane;
      bit     trunc;
      cur  = '0;
      cum  = 0;
      lane = 0;
      foreach (pkt[i]) begin
         cum += $countones(pkt[i].k);
         for (int b = 0; b < SK; b++)
            cur.d[lane*SW + b*8 +: 8] = pkt[i].k[b] ? pkt[i].d[b*8 +: 8] : 8'h00;
         cur.k[lane*SK +: SK] = pkt[i].k;
         lane++;
         trunc = !pkt[i].last && cum > MAXL;
         if (lane == N || pkt[i].last || trunc) begin
            cur.len  = PLW'(cum);
            cur.last = pkt[i].last || trunc;
            cur.bad  = (pkt[i].last && pkt[i].user) || trunc;
            exp_q.push_back(cur);
            if (cur.last) begin
               exp_pkts++;
               if (cur.bad)
                  exp_bad++;
            end
            cur  = '0;
            lane = 0;
            if (trunc)
               break;
         end
      end
   endtask

   task automatic drive_beat(input nbeat_t b);
      int budget;
      bit rdy;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.last;
      s_axis_tuser  = b.user;
      budget = 0;
      do begin
         @(negedge aclk);
         rdy = s_axis_tready;
         @(posedge aclk);
         #1;
         budget++;
      end while (!rdy && budget < 200);
      if (!rdy) begin
         tests++;
         fails++;
         $display("FAIL drive_timeout s_axis_tready=%b required 1", rdy);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_pkt();
      foreach (pkt[i])
         drive_beat(pkt[i]);
   endtask

   task automatic wait_drain(input int max);
      int c;
      c = 0;
      while (obs_q.size() < exp_q.size() && c < max) begin
         @(posedge aclk);
         c++;
      end
      repeat (8) @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      tests++;
      if ({m_axis_tvalid, m_axis_tlast, m_bad, s_axis_tready} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ctrl valid/last/bad/ready=%b required 0000",
                  {m_axis_tvalid, m_axis_tlast, m_bad, s_axis_tready});
      end
      tests++;
      if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_len !== '0) begin
         fails++;
         $display("FAIL reset_data data=%h keep=%h len=%0d required 0",
                  m_axis_tdata, m_axis_tkeep, m_len);
      end
      tests++;
      if (stat_pkt_count !== 32'd0 || stat_bad_count !== 32'd0) begin
         fails++;
         $display("FAIL reset_stats pkt=%0d bad=%0d required 0",
                  stat_pkt_count, stat_bad_count);
      end
      @(posedge aclk);
      #1;
      rst = 1'b0;
      exp_pkts = 0;
      exp_bad  = 0;
      @(posedge aclk);
      #1;
   endtask

   task automatic test_full_64();
      logic [MW-1:0] d0, d1;
      obs_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      build_pkt(64, 1'b0, 1'b0);
      model_pkt();
      d0 = {pkt[3].d, pkt[2].d, pkt[1].d, pkt[0].d};
      d1 = {pkt[7].d, pkt[6].d, pkt[5].d, pkt[4].d};
      send_pkt();
      wait_drain(100);
      tests++;
      if (obs_q.size() !== 2) begin
         fails++;
         $display("FAIL full64_count got %0d required 2", obs_q.size());
      end else begin
         tests++;
         if (obs_q[0].k !== 32'hFFFFFFFF || obs_q[0].len !== 14'd32 ||
             obs_q[0].last !== 1'b0 || obs_q[0].d !== d0) begin
            fails++;
            $display("FAIL full64_beat0 keep=%h len=%0d last=%b required FFFFFFFF 32 0",
                     obs_q[0].k, obs_q[0].len, obs_q[0].last);
         end
         tests++;
         if (obs_q[1].k !== 32'hFFFFFFFF || obs_q[1].len !== 14'd64 ||
             obs_q[1].last !== 1'b1 || obs_q[1].bad !== 1'b0 || obs_q[1].d !== d1) begin
            fails++;
            $display("FAIL full64_beat1 keep=%h len=%0d last=%b bad=%b required FFFFFFFF 64 1 0",
                     obs_q[1].k, obs_q[1].len, obs_q[1].last, obs_q[1].bad);
         end
      end
      tests++;
      if (stat_pkt_count !== 32'd1) begin
         fails++;
         $display("FAIL full64_stat got %0d required 1", stat_pkt_count);
      end
      tests++;
      if (m_in_port !== 3'd0 || m_in_vport !== 3'd0 ||
          m_out_port !== 8'd0 || m_out_vport !== 8'd0) begin
         fails++;
         $display("FAIL full64_ports in=%0d/%0d out=%0d/%0d required 0",
                  m_in_port, m_in_vport, m_out_port, m_out_vport);
      end
   endtask

   task automatic test_partial_61();
      obs_q.delete();
      exp_q.delete();
      build_pkt(61, 1'b0, 1'b0);
      model_pkt();
      send_pkt();
      wait_drain(100);
      tests++;
      if (obs_q.size() !== 2) begin
         fails++;
         $display("FAIL p61_count got %0d required 2", obs_q.size());
      end else begin
         tests++;
         if (obs_q[1].k !== 32'h1FFFFFFF || obs_q[1].len !== 14'd61 ||
             obs_q[1].last !== 1'b1 || obs_q[1].d[MW-1:MW-24] !== 24'h0) begin
            fails++;
            $display("FAIL p61_last keep=%h len=%0d last=%b top=%h required 1FFFFFFF 61 1 0",
                     obs_q[1].k, obs_q[1].len, obs_q[1].last, obs_q[1].d[MW-1:MW-24]);
         end
         tests++;
         if (obs_q[1] !== exp_q[1]) begin
            fails++;
            $display("FAIL p61_model got d=%h required d=%h", obs_q[1].d, exp_q[1].d);
         end
      end
   endtask

   task automatic test_single_bad();
      obs_q.delete();
      exp_q.delete();
      build_pkt(4, 1'b1, 1'b0);
      model_pkt();
      send_pkt();
      wait_drain(100);
      tests++;
      if (obs_q.size() !== 1) begin
         fails++;
         $display("FAIL single_count got %0d required 1", obs_q.size());
      end else begin
         tests++;
         if (obs_q[0].k !== 32'h0000000F || obs_q[0].len !== 14'd4 ||
             obs_q[0].last !== 1'b1 || obs_q[0].bad !== 1'b1 ||
             obs_q[0].d[MW-1:32] !== '0) begin
            fails++;
            $display("FAIL single_beat keep=%h len=%0d last=%b bad=%b required 0000000F 4 1 1",
                     obs_q[0].k, obs_q[0].len, obs_q[0].last, obs_q[0].bad);
         end
      end
      tests++;
      if (stat_bad_count !== 32'd1 || stat_pkt_count !== 32'd3) begin
         fails++;
         $display("FAIL single_stats pkt=%0d bad=%0d required 3 1",
                  stat_pkt_count, stat_bad_count);
      end
   endtask

   task automatic test_random();
      obs_q.delete();
      exp_q.delete();
      rand_rdy = 1'b1;
      for (int p = 0; p < 25; p++) begin
         build_pkt($urandom_range(1, 300), 1'($urandom), 1'b1);
         model_pkt();
         send_pkt();
      end
      wait_drain(5000);
      rand_rdy = 1'b0;
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b1;
      tests++;
      if (obs_q.size() !== exp_q.size()) begin
         fails++;
         $display("FAIL rand_count got %0d required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL rand_beat%0d got d=%h k=%h len=%0d last=%b bad=%b required d=%h k=%h len=%0d last=%b bad=%b",
                     i, obs_q[i].d, obs_q[i].k, obs_q[i].len, obs_q[i].last, obs_q[i].bad,
                     exp_q[i].d, exp_q[i].k, exp_q[i].len, exp_q[i].last, exp_q[i].bad);
         end
      end
      tests++;
      if (stat_pkt_count !== 32'(exp_pkts) || stat_bad_count !== 32'(exp_bad)) begin
         fails++;
         $display("FAIL rand_stats pkt=%0d bad=%0d required %0d %0d",
                  stat_pkt_count, stat_bad_count, exp_pkts, exp_bad);
      end
   endtask

   task automatic test_backpressure();
      logic [MW+MK+PLW+3-1:0] snap, now;
      int c;
      obs_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      build_pkt(128, 1'b0, 1'b0);
      model_pkt();
      send_done = 1'b0;
      fork
         begin
            send_pkt();
            send_done = 1'b1;
         end
      join_none
      c = 0;
      while (obs_q.size() < 1 && c < 100) begin
         @(posedge aclk);
         c++;
      end
      #1;
      m_axis_tready = 1'b0;
      c = 0;
      while (!m_axis_tvalid && c < 100) begin
         @(posedge aclk);
         #1;
         c++;
      end
      @(negedge aclk);
      snap = {m_axis_tdata, m_axis_tkeep, m_len, m_axis_tlast, m_bad, m_axis_tvalid};
      tests++;
      if (m_axis_tvalid !== 1'b1) begin
         fails++;
         $display("FAIL bp_valid got %b required 1", m_axis_tvalid);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         now = {m_axis_tdata, m_axis_tkeep, m_len, m_axis_tlast, m_bad, m_axis_tvalid};
         tests++;
         if (now !== snap || s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold cycle%0d s_tready=%b stable=%b required 0 1",
                     i, s_axis_tready, now === snap);
         end
      end
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b1;
      c = 0;
      while (!send_done && c < 500) begin
         @(posedge aclk);
         c++;
      end
      wait_drain(200);
      tests++;
      if (obs_q.size() !== exp_q.size()) begin
         fails++;
         $display("FAIL bp_count got %0d required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL bp_beat%0d got k=%h len=%0d last=%b required k=%h len=%0d last=%b",
                     i, obs_q[i].k, obs_q[i].len, obs_q[i].last,
                     exp_q[i].k, exp_q[i].len, exp_q[i].last);
         end
      end
   endtask

   task automatic test_truncation();
      obs_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      build_pkt(12000, 1'b0, 1'b0);
      model_pkt();
      send_pkt();
      build_pkt(100, 1'b0, 1'b0);
      model_pkt();
      send_pkt();
      wait_drain(2000);
      tests++;
      if (obs_q.size() !== 317 || exp_q.size() !== 317) begin
         fails++;
         $display("FAIL trunc_count got %0d required 317 (model %0d)",
                  obs_q.size(), exp_q.size());
      end
      if (obs_q.size() > 312) begin
         tests++;
         if (obs_q[312].len !== 14'd10008 || obs_q[312].k !== 32'h00FFFFFF ||
             obs_q[312].last !== 1'b1 || obs_q[312].bad !== 1'b1) begin
            fails++;
            $display("FAIL trunc_beat len=%0d keep=%h last=%b bad=%b required 10008 00FFFFFF 1 1",
                     obs_q[312].len, obs_q[312].k, obs_q[312].last, obs_q[312].bad);
         end
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL trunc_beat%0d got k=%h len=%0d last=%b bad=%b required k=%h len=%0d last=%b bad=%b",
                     i, obs_q[i].k, obs_q[i].len, obs_q[i].last, obs_q[i].bad,
                     exp_q[i].k, exp_q[i].len, exp_q[i].last, exp_q[i].bad);
         end
      end
      tests++;
      if (stat_pkt_count !== 32'(exp_pkts) || stat_bad_count !== 32'(exp_bad)) begin
         fails++;
         $display("FAIL trunc_stats pkt=%0d bad=%0d required %0d %0d",
                  stat_pkt_count, stat_bad_count, exp_pkts, exp_bad);
      end
   endtask

   task automatic test_reset_mid();
      obs_q.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      build_pkt(64, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         drive_beat(pkt[i]);
      rst = 1'b1;
      @(negedge aclk);
      tests++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
         fails++;
         $display("FAIL rmid_ctrl valid=%b ready=%b required 0 0",
                  m_axis_tvalid, s_axis_tready);
      end
      @(posedge aclk);
      #1;
      tests++;
      if (stat_pkt_count !== 32'd0 || stat_bad_count !== 32'd0) begin
         fails++;
         $display("FAIL rmid_stats pkt=%0d bad=%0d required 0 0",
                  stat_pkt_count, stat_bad_count);
      end
      rst = 1'b0;
      exp_pkts = 0;
      exp_bad  = 0;
      obs_q.delete();
      @(posedge aclk);
      #1;
      build_pkt(32, 1'b0, 1'b0);
      model_pkt();
      send_pkt();
      wait_drain(100);
      tests++;
      if (obs_q.size() !== 1) begin
         fails++;
         $display("FAIL rmid_count got %0d required 1", obs_q.size());
      end else begin
         tests++;
         if (obs_q[0] !== exp_q[0] || obs_q[0].len !== 14'd32 ||
             obs_q[0].k !== 32'hFFFFFFFF || obs_q[0].last !== 1'b1) begin
            fails++;
            $display("FAIL rmid_beat len=%0d keep=%h last=%b required 32 FFFFFFFF 1",
                     obs_q[0].len, obs_q[0].k, obs_q[0].last);
         end
      end
      tests++;
      if (stat_pkt_count !== 32'd1) begin
         fails++;
         $display("FAIL rmid_stat got %0d required 1", stat_pkt_count);
      end
   endtask

   initial begin
      test_reset();
      test_full_64();
      test_partial_61();
      test_single_bad();
      test_random();
      test_backpressure();
      test_truncation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
